// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered ALU with valid/ready handshakes and bit-serial shifter
module alu_seq_param #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [2:0]       Control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Cout,
   output logic             Zero,
   output logic             Neg,
   output logic             Ovf
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   cnt;
   logic [1:0]       sh_op;

   logic             accept;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] imm_result;
   logic             imm_cout;
   logic             imm_ovf;
   logic [WIDTH-1:0] step_next;
   logic             step_bit;

   // A new op may enter when idle, or when the held result leaves on this same edge
   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   assign sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
   assign diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};

   // Single-cycle results: arithmetic, logic, and shifts by zero (which return A untouched)
   always_comb begin
      imm_result = A;
      imm_cout   = 1'b0;
      imm_ovf    = 1'b0;
      case (Control)
         3'b000: begin
            imm_result = sum[WIDTH-1:0];
            imm_cout   = sum[WIDTH];
            imm_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         3'b001: begin
            imm_result = diff[WIDTH-1:0];
            imm_cout   = diff[WIDTH];
            imm_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         3'b010:  imm_result = A | B;
         3'b011:  imm_result = A & B;
         default: imm_result = A;
      endcase
   end

   // One-bit move of the working register; sh_op is the low two opcode bits (SHL, SHR, ROL, ROR)
   always_comb begin
      step_next = work;
      step_bit  = 1'b0;
      case (sh_op)
         2'b00: begin
            step_next = {work[WIDTH-2:0], 1'b0};
            step_bit  = work[WIDTH-1];
         end
         2'b01: begin
            step_next = {1'b0, work[WIDTH-1:1]};
            step_bit  = work[0];
         end
         2'b10:   step_next = {work[WIDTH-2:0], work[WIDTH-1]};
         default: step_next = {work[0], work[WIDTH-1:1]};
      endcase
   end

   // Control FSM with registered result, flags and out_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         Result    <= '0;
         Cout      <= 1'b0;
         Zero      <= 1'b0;
         Neg       <= 1'b0;
         Ovf       <= 1'b0;
         work      <= '0;
         cnt       <= '0;
         sh_op     <= 2'b00;
      end else begin
         case (state)
            SHIFT: begin
               work <= step_next;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  Result    <= step_next;
                  Cout      <= step_bit;
                  Zero      <= (step_next == '0);
                  Neg       <= step_next[WIDTH-1];
                  Ovf       <= 1'b0;
               end
            end
            default: begin
               if (accept) begin
                  if (!Control[2] || (B[SHW-1:0] == '0)) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     Result    <= imm_result;
                     Cout      <= imm_cout;
                     Zero      <= (imm_result == '0);
                     Neg       <= imm_result[WIDTH-1];
                     Ovf       <= imm_ovf;
                  end else begin
                     state     <= SHIFT;
                     out_valid <= 1'b0;
                     work      <= A;
                     cnt       <= B[SHW-1:0];
                     sh_op     <= Control[1:0];
                  end
               end else if (state == DONE && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - randomized and directed checks of alu_seq_param against a behavioural model
module tb_alu_seq_param;

   localparam int W   = 16;
   localparam int SHW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          Cin = 1'b0;
   logic [2:0]    Control = 3'b000;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  Result;
   logic          Cout, Zero, Neg, Ovf;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int acc_cyc = 0;

   alu_seq_param #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Control(Control),
      .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Cout(Cout), .Zero(Zero), .Neg(Neg), .Ovf(Ovf)
   );

   always #5 clk = ~clk;

   // Counts rising edges; an op accepted at edge k sees cyc==k afterwards
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference semantics from plain integer arithmetic; lat = extra edges after acceptance
   task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [2:0] ctl, output logic [W-1:0] r, output logic co,
                           output logic ov, output int lat);
      int n, ua, ub, sa, sb, s;
      n  = int'(b[SHW-1:0]);
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      co = 1'b0; ov = 1'b0; lat = 0; r = a;
      case (ctl)
         3'd0: begin
            s = ua + ub + int'(cin);
            r = s[W-1:0]; co = (s >= (1 << W));
            s = sa + sb + int'(cin);
            ov = (s > 32767) || (s < -32768);
         end
         3'd1: begin
            s = ua - ub - int'(cin);
            r = s[W-1:0]; co = (s < 0);
            s = sa - sb - int'(cin);
            ov = (s > 32767) || (s < -32768);
         end
         3'd2: r = a | b;
         3'd3: r = a & b;
         3'd4: begin r = a << n; co = (n > 0) ? a[W-n] : 1'b0; lat = n; end
         3'd5: begin r = a >> n; co = (n > 0) ? a[n-1] : 1'b0; lat = n; end
         3'd6: begin r = (n > 0) ? ((a << n) | (a >> (W - n))) : a; lat = n; end
         default: begin r = (n > 0) ? ((a >> n) | (a << (W - n))) : a; lat = n; end
      endcase
   endtask

   logic          pend = 1'b0;
   int            p_ready = 0;
   logic [W-1:0]  p_r;
   logic          p_co, p_ov;

   // Compare process: predicts handshake signals and result every cycle
   always @(negedge clk) begin
      logic exp_ov, exp_ir;
      int   lat;
      if (!rst_n) begin
         pend = 1'b0;
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_in_ready", in_ready, 1'b1);
         chk("rst_result", Result, 16'h0000);
      end else begin
         exp_ov = pend && (cyc >= p_ready);
         exp_ir = !pend || (exp_ov && out_ready);
         chk("out_valid", out_valid, exp_ov);
         chk("in_ready", in_ready, exp_ir);
         if (exp_ov && out_valid) begin
            chk("result", Result, p_r);
            chk("cout", Cout, p_co);
            chk("ovf", Ovf, p_ov);
            chk("zero", Zero, (p_r == 0));
            chk("neg", Neg, p_r[W-1]);
         end
         if (exp_ov && out_ready) pend = 1'b0;
         if (in_valid && exp_ir) begin
            model_op(A, B, Cin, Control, p_r, p_co, p_ov, lat);
            pend    = 1'b1;
            p_ready = cyc + 1 + lat;
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [2:0] ctl);
      @(posedge clk); #1;
      in_valid = 1'b1; A = a; B = b; Cin = cin; Control = ctl;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      chk("accept_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic get_result(output int lat, output int busy);
      busy = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (out_valid) break;
         if (!in_ready) busy++;
      end
      chk("result_timeout", out_valid, 1'b1);
      lat = cyc - acc_cyc;
   endtask

   task automatic expect_res(input string name, input logic [W-1:0] r, input logic co,
                             input logic z, input logic ng, input logic ov, input int lat_exp);
      int lat, busy;
      get_result(lat, busy);
      chk({name, "_result"}, Result, r);
      chk({name, "_cout"}, Cout, co);
      chk({name, "_zero"}, Zero, z);
      chk({name, "_neg"}, Neg, ng);
      chk({name, "_ovf"}, Ovf, ov);
      chk({name, "_latency"}, lat, lat_exp);
      chk({name, "_busy"}, busy, lat_exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_flags", {Cout, Zero, Neg, Ovf}, 4'b0000);
      @(posedge clk); #1 rst_n = 1'b1;

      send(16'hFFFF, 16'h0001, 1'b0, 3'b000);
      expect_res("add_wrap", 16'h0000, 1, 1, 0, 0, 0);
      send(16'h8000, 16'h0001, 1'b0, 3'b001);
      expect_res("sub_ovf", 16'h7FFF, 0, 0, 0, 1, 0);
      send(16'h0000, 16'h0000, 1'b1, 3'b001);
      expect_res("sub_borrow", 16'hFFFF, 1, 0, 1, 0, 0);
      send(16'h0009, 16'h0004, 1'b0, 3'b101);
      expect_res("shr4", 16'h0000, 1, 1, 0, 0, 4);
      send(16'h8001, 16'h0001, 1'b0, 3'b100);
      expect_res("shl1", 16'h0002, 1, 0, 0, 0, 1);
      send(16'h8001, 16'h000F, 1'b0, 3'b110);
      expect_res("rol15", 16'hC000, 0, 0, 1, 0, 15);
      send(16'h0001, 16'h0000, 1'b0, 3'b111);
      expect_res("ror0", 16'h0001, 0, 0, 0, 0, 0);

      // Backpressure, then a new op accepted on the consuming edge
      @(posedge clk); #1 out_ready = 1'b0;
      send(16'h1234, 16'h0101, 1'b0, 3'b000);
      begin
         int lat, busy;
         get_result(lat, busy);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_result", Result, 16'h1335);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; A = 16'h00F0; B = 16'h0F00; Control = 3'b010;
      @(negedge clk);
      chk("bp_accept_ready", in_ready, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_or_result", Result, 16'h0FF0);
      chk("bp_or_valid", out_valid, 1'b1);

      // Reset in the middle of a shift
      send(16'h1234, 16'h000A, 1'b0, 3'b100);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_result", Result, 16'h0000);
      chk("midrst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(16'h0002, 16'h0003, 1'b0, 3'b000);
      expect_res("post_rst_add", 16'h0005, 0, 0, 0, 0, 0);

      // Randomized traffic, checked by the compare process
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         A         = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
         B         = W'($urandom);
         Cin       = 1'($urandom);
         Control   = 3'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("drain_idle", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
